demux_1x8_32bit_regbank: RTL
============================

# demux_1x8_32bit_regbank

Registered 1-to-8, 32-bit demultiplexer: routes one 32-bit write word to one of eight storage slots selected by a 3-bit code and holds each slot's value. It is the write-side counterpart of the 8x1 32-bit read multiplexer in the processor datapath. The eight slot outputs feed that multiplexer's `in_0`..`in_7` directly. Per-slot valid flags tell the control unit which slots hold written data.

## Interface
- No parameters; width fixed at 32, slot count fixed at 8.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high reset.
- `clear` input 1: synchronous clear of all slots and valid flags.
- `wr_en` input 1: write strobe, sampled at the rising edge of `clk`.
- `wr_sel` input 3: destination slot; 000 selects slot 0, 111 selects slot 7.
- `wr_data` input 32: word to store.
- `out_0`..`out_7` output 32 each: registered slot contents.
- `valid` output 8: bit i is set once slot i has been written since the last reset or clear.
- `wr_count` output 4: number of set `valid` bits (0..8).
- `last_sel` output 3: slot index of the most recent accepted write.

## Operation
- Decode: `wr_sel` is one-hot decoded to `hit[7:0]`. Slot i's enable is `wr_en & hit[i]`. The decode is gate-level (not/and per select bit combination), mirroring the read mux.
- Accepted write: slot i loads `wr_data`. `valid[i]` is set. `last_sel` takes `wr_sel`. Other slots hold their values.
- Rewriting a slot that is already valid:
  - data is overwritten;
  - `valid` is unchanged;
  - `wr_count` is unchanged.
- `wr_count` is a registered counter:
  - increments on an accepted write to a slot whose `valid` bit was 0;
  - otherwise holds;
  - it always equals the population count of `valid`;
  - it saturates naturally at 8 and never wraps.
- `clear` resets all `out_i` to 0, `valid` to 0, `wr_count` to 0 and `last_sel` to 0.
- Priority when events coincide: `reset` > `clear` > `wr_en`.
  - `clear` and `wr_en` in the same cycle: the write is dropped.
- `wr_en` = 0: no state changes; `wr_sel` and `wr_data` are don't-care.
- X on `wr_sel` while `wr_en` = 1 is illegal; the bench flags it as an error.

## Timing
- Reset values while `reset` is high, applied immediately without waiting for a clock edge:
  - `out_0`..`out_7` = 32'h0000_0000;
  - `valid` = 8'h00;
  - `wr_count` = 4'd0;
  - `last_sel` = 3'd0.
- Write latency is 1 cycle: data presented at edge N is visible on `out_i` after edge N, so it is readable through the read mux in cycle N+1. There is no same-cycle write-to-read bypass.
- `valid`, `wr_count` and `last_sel` update on the same edge as the slot data.
- Back-to-back writes to any slots, including the same slot, are accepted every cycle with no stall.
- Reset deasserting mid-sequence: the first write is accepted at the first rising edge after deassertion. Writes presented while reset is high are lost.

## Configuration
- Macro `ZERO_SLOT_EN`.
- When defined, slot 0 is hardwired to zero, for a register-zero convention:
  - `out_0` is constant 0;
  - writes with `wr_sel` = 000 are ignored: no data change, `valid[0]` is not set, `last_sel` and `wr_count` are not updated;
  - `valid[0]` reads 1 at all times, including during reset;
  - `wr_count` reset/clear value is 1 and its maximum is 8.
- When not defined, slot 0 behaves like every other slot.

## Test plan
- Reset values and back-to-back fill:
  - Stimulus: assert `reset` asynchronously mid-cycle, release it, then write 32'hA0000000+i to slot i for i = 0..7 on consecutive cycles.
  - Response: all outputs are at reset values immediately. Each `out_i` matches one cycle after its write. `valid` = 8'hFF, `wr_count` = 8, `last_sel` = 7.
- Overwrite of a valid slot:
  - Stimulus: write 32'h1234_5678 to slot 3, then 32'hDEAD_BEEF to slot 3.
  - Response: `out_3` = 32'hDEAD_BEEF. `wr_count` = 1. `valid` = 8'h08. All other slots are 0.
- Clear and write coincide:
  - Stimulus: fill slots 1 and 5, then pulse `clear` together with `wr_en`, `wr_sel` = 2, `wr_data` = 32'hFFFF_FFFF.
  - Response: all slots are 0. `valid` = 0. `wr_count` = 0. `out_2` = 0.
- Write-enable gating:
  - Stimulus: `wr_en` = 0 while `wr_sel` and `wr_data` toggle randomly for 20 cycles.
  - Response: no output changes.
- Slot 0 write:
  - Stimulus: write 32'hCAFE_F00D to slot 0.
  - Response with `ZERO_SLOT_EN` defined: `out_0` = 0, `valid` = 8'h01, `wr_count` = 1.
  - Response without it: `out_0` = 32'hCAFE_F00D, `valid` = 8'h01, `wr_count` = 1.
- Reset mid-stream:
  - Stimulus: assert `reset` between two writes to slot 6.
  - Response: the second write, which lands after release, is the only value present. `wr_count` = 1.

Source files
------------

// File: rtl/demux_1x8_32bit_regbank_if.sv
// Bus bundle for the 1-to-8 32-bit write demux / slot bank.
// Carries write controls in and the eight slot words plus status out.
interface demux_1x8_32bit_regbank_if;
   logic        clear;
   logic        wr_en;
   logic [2:0]  wr_sel;
   logic [31:0] wr_data;
   logic [31:0] out_0;
   logic [31:0] out_1;
   logic [31:0] out_2;
   logic [31:0] out_3;
   logic [31:0] out_4;
   logic [31:0] out_5;
   logic [31:0] out_6;
   logic [31:0] out_7;
   logic [7:0]  valid;
   logic [3:0]  wr_count;
   logic [2:0]  last_sel;

   modport master (
      output clear, wr_en, wr_sel, wr_data,
      input  out_0, out_1, out_2, out_3, out_4, out_5, out_6, out_7,
      input  valid, wr_count, last_sel
   );

   modport slave (
      input  clear, wr_en, wr_sel, wr_data,
      output out_0, out_1, out_2, out_3, out_4, out_5, out_6, out_7,
      output valid, wr_count, last_sel
   );
endinterface

// File: rtl/demux_1x8_32bit_regbank.sv
// Registered 1-to-8 32-bit write demux holding eight slots with valid flags.
// Define ZERO_SLOT_EN to hardwire slot 0 to zero (register-zero convention).
module demux_1x8_32bit_regbank (
   input logic                      clk,
   input logic                      reset,
   demux_1x8_32bit_regbank_if.slave bus
);
   localparam int unsigned DW = 32;
   localparam int unsigned NS = 8;
   localparam int unsigned CW = 4;
   localparam int unsigned SW = 3;

`ifdef ZERO_SLOT_EN
   localparam logic [NS-1:0] VALID_RST = 8'h01;
   localparam logic [CW-1:0] CNT_RST   = 4'd1;
   localparam logic [NS-1:0] SLOT_MASK = 8'hFE;
`else
   localparam logic [NS-1:0] VALID_RST = 8'h00;
   localparam logic [CW-1:0] CNT_RST   = 4'd0;
   localparam logic [NS-1:0] SLOT_MASK = 8'hFF;
`endif

   logic [SW-1:0] sel_n_c;
   logic [NS-1:0] hit_c;
   logic [NS-1:0] en_c;
   logic          new_c;

   logic [DW-1:0] slot_q [NS];
   logic [DW-1:0] slot_d [NS];
   logic [NS-1:0] valid_q, valid_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic [SW-1:0] last_q,  last_d;

   // Gate-level one-hot decode, same structure as the read mux select tree
   assign sel_n_c  = ~bus.wr_sel;
   assign hit_c[0] = sel_n_c[2]    & sel_n_c[1]    & sel_n_c[0];
   assign hit_c[1] = sel_n_c[2]    & sel_n_c[1]    & bus.wr_sel[0];
   assign hit_c[2] = sel_n_c[2]    & bus.wr_sel[1] & sel_n_c[0];
   assign hit_c[3] = sel_n_c[2]    & bus.wr_sel[1] & bus.wr_sel[0];
   assign hit_c[4] = bus.wr_sel[2] & sel_n_c[1]    & sel_n_c[0];
   assign hit_c[5] = bus.wr_sel[2] & sel_n_c[1]    & bus.wr_sel[0];
   assign hit_c[6] = bus.wr_sel[2] & bus.wr_sel[1] & sel_n_c[0];
   assign hit_c[7] = bus.wr_sel[2] & bus.wr_sel[1] & bus.wr_sel[0];

   assign en_c  = {NS{bus.wr_en}} & hit_c & SLOT_MASK;
   assign new_c = |(en_c & ~valid_q);

   // Next state: clear dominates any coincident write
   always_comb begin
      slot_d  = slot_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      if (bus.clear) begin
         for (int unsigned i = 0; i < NS; i++) slot_d[i] = '0;
         valid_d = VALID_RST;
         cnt_d   = CNT_RST;
         last_d  = '0;
      end else if (|en_c) begin
         for (int unsigned i = 0; i < NS; i++) begin
            if (en_c[i]) slot_d[i] = bus.wr_data;
         end
         valid_d = valid_q | en_c;
         if (new_c) cnt_d = cnt_q + CW'(1);
         last_d = bus.wr_sel;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NS; i++) slot_q[i] <= '0;
         valid_q <= VALID_RST;
         cnt_q   <= CNT_RST;
         last_q  <= '0;
      end else begin
         for (int unsigned i = 0; i < NS; i++) slot_q[i] <= slot_d[i];
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
      end
   end

   // Slot 0 is never loaded when hardwired, so its register stays at zero
   assign bus.out_0    = slot_q[0];
   assign bus.out_1    = slot_q[1];
   assign bus.out_2    = slot_q[2];
   assign bus.out_3    = slot_q[3];
   assign bus.out_4    = slot_q[4];
   assign bus.out_5    = slot_q[5];
   assign bus.out_6    = slot_q[6];
   assign bus.out_7    = slot_q[7];
   assign bus.valid    = valid_q;
   assign bus.wr_count = cnt_q;
   assign bus.last_sel = last_q;
endmodule
